// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, strobes the instruction memory and
// holds one fetched instruction for decode behind a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    ISSUE,
    WAIT,
    HELD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] instr_n;
  logic [31:0] instr_pc_n;
  logic        valid_n;
  logic        take_redirect;

  assign take_redirect = redirect_valid && (state != BOOT);

  assign mem_addr  = pc;
  assign mem_rstrb = (state == ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    valid_n    = instr_valid;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    // A redirect also drops any in-flight response and the held instruction.
    if (take_redirect) begin
      state_n = ISSUE;
      pc_n    = redirect_pc & 32'hFFFF_FFFC;
      valid_n = 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state_n = ISSUE;
        end
        ISSUE: begin
          state_n = WAIT;
        end
        WAIT: begin
          state_n    = HELD;
          instr_n    = mem_rdata;
          instr_pc_n = pc;
          valid_n    = 1'b1;
        end
        HELD: begin
          if (instr_ready) begin
            state_n = ISSUE;
            pc_n    = pc + 32'd4;
            valid_n = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-countdown model plus directed scenarios
// with literal expectations for strobes and accepted instructions.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  int n;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: word at byte address a is A000_0000 | word index.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0000 | {2'b00, a[31:2]};
  endfunction

  always @(posedge clk)
    if (mem_rstrb) mem_rdata <= word(mem_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: next fetch address plus a countdown of edges until it is presented.
  bit          m_boot;
  int          m_eta;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_boot  <= 1'b1;
      m_eta   <= 3;
      m_valid <= 1'b0;
      m_pc    <= RESET_PC;
      m_instr <= NOP;
      m_ipc   <= RESET_PC;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_eta  <= 2;
    end else if (redirect_valid) begin
      m_pc    <= redirect_pc & ~32'h3;
      m_eta   <= 2;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_pc    <= m_pc + 32'd4;
        m_eta   <= 2;
        m_valid <= 1'b0;
      end
    end else begin
      m_eta <= m_eta - 1;
      if (m_eta == 1) begin
        m_valid <= 1'b1;
        m_instr <= word(m_pc);
        m_ipc   <= m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (vectors >= 0 && $time > 2) begin
      check("strobe", {31'b0, mem_rstrb},
            {31'b0, (!reset && !m_boot && !m_valid && m_eta == 2)});
      check("mem_addr", mem_addr, m_pc);
      check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
    end
  end

  logic [31:0] strobe_q[$];
  logic [63:0] acc_q[$];

  always @(negedge clk)
    if (!reset) begin
      if (mem_rstrb) strobe_q.push_back(mem_addr);
      if (instr_valid && instr_ready) acc_q.push_back({instr, instr_pc});
    end

  function automatic logic [31:0] strobe_at(input int i);
    return (strobe_q.size() > i) ? strobe_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [63:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    strobe_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int k;
    k = 0;
    while (!instr_valid && k < 20) begin
      step();
      k++;
    end
    check({name, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({name, "_pc"}, instr_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Straight-line fetch with decode always ready.
    do_reset();
    instr_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_valid && n < 10);
    check("first_valid_edges", n, 3);
    n = 0;
    while (acc_q.size() < 4 && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check("s1_instr", acc_at(i)[63:32], 32'hA000_0000 + i);
      check("s1_pc", acc_at(i)[31:0], 4 * i);
      check("s1_strobe", strobe_at(i), 4 * i);
    end

    // Back-pressure on the word at 4.
    do_reset();
    wait_valid("s2_v0", 32'h0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid("s2_v4", 32'h4);
    strobe_q.delete();
    repeat (5) step();
    check("s2_no_strobe", strobe_q.size(), 0);
    check("s2_valid", {31'b0, instr_valid}, 32'd1);
    check("s2_instr", instr, 32'hA000_0001);
    check("s2_pc", instr_pc, 32'h4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (2) step();
    check("s2_next_strobe", strobe_at(0), 32'h8);

    // Redirect while the fetch of 4 is in flight.
    do_reset();
    wait_valid("s3_v0", 32'h0);
    strobe_q.delete();
    acc_q.delete();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      step();
      n++;
    end
    instr_ready = 1'b0;
    check("s3_acc0", acc_at(0)[31:0], 32'h0);
    check("s3_acc1_pc", acc_at(1)[31:0], 32'h20);
    check("s3_acc1_instr", acc_at(1)[63:32], 32'hA000_0008);
    check("s3_strobe0", strobe_at(0), 32'h4);
    check("s3_strobe1", strobe_at(1), 32'h20);

    // Redirect coinciding with acceptance; low bits of the target dropped.
    do_reset();
    wait_valid("s4_v0", 32'h0);
    strobe_q.delete();
    acc_q.delete();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h13;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    wait_valid("s4_v10", 32'h10);
    check("s4_acc_count", acc_q.size(), 1);
    check("s4_acc0", acc_at(0)[63:32], 32'hA000_0000);
    check("s4_strobe", strobe_at(0), 32'h10);
    check("s4_instr", instr, 32'hA000_0004);

    // Wrap-around from the top word.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid("s5_vtop", 32'hFFFF_FFFC);
    check("s5_instr_top", instr, 32'hBFFF_FFFF);
    strobe_q.delete();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid("s5_vwrap", 32'h0);
    check("s5_strobe", strobe_at(0), 32'h0);
    check("s5_instr", instr, 32'hA000_0000);

    // Asynchronous reset while holding; a redirect during boot is ignored.
    #3;
    reset = 1'b1;
    #1;
    check("s6_valid_async", {31'b0, instr_valid}, 32'd0);
    check("s6_strobe_async", {31'b0, mem_rstrb}, 32'd0);
    check("s6_instr_async", instr, NOP);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    strobe_q.delete();
    acc_q.delete();
    step();
    redirect_valid = 1'b0;
    n = 1;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    check("s6_first_valid_edges", n, 3);
    check("s6_pc", instr_pc, RESET_PC);
    check("s6_strobe", strobe_at(0), RESET_PC);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
